// File: rtl/mac_pkg.sv
// Shared defaults, mode encodings and width helper for the MAC vector unit.
// Imported by mac_opnd_buf and mac_vec.
package mac_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int VEC_LEN_DEF = 8;
  localparam int ACC_W_DEF   = 11;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Ceiling log2, never below 1 so a counter always has a bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mac_opnd_buf.sv
// One-entry operand holding register with valid/ready.
// A take on the same edge as an accept lets the entry refill in place.
module mac_opnd_buf
  import mac_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         take_i,
  output logic         full_o,
  output logic [W-1:0] q_o
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         accept;

  assign ready_o = !full_q || take_i;
  assign accept  = valid_i && ready_o;
  assign full_o  = full_q;
  assign q_o     = data_q;

  // Next entry state: accept loads, take alone empties.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = d_i;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/mac_vec.sv
// Dot-product MAC over VEC_LEN operand pairs with independent A/B streams.
// Define MAC_SATURATE_EN to clamp each accumulation step instead of wrapping.
module mac_vec
  import mac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_valid_a,
  output logic              in_ready_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid_b,
  output logic              in_ready_b,
  input  logic              in_signed,
  output logic [ACC_W-1:0]  mac_out,
  output logic              out_valid
);

  localparam int CNT_W = clog2(VEC_LEN);
  localparam int PW    = 2 * DATA_W;

  logic              a_full;
  logic              b_full;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              fire;
  logic              last;
  logic              eff_sgn;

  logic signed [PW-1:0] ps;
  logic [PW-1:0]        pu;
  logic [ACC_W-1:0]     pext;
  logic [ACC_W-1:0]     acc_n;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mode_q;
  logic             mode_d;
  logic [ACC_W-1:0] mac_q;
  logic [ACC_W-1:0] mac_d;
  logic             ov_q;
  logic             ov_d;

  mac_opnd_buf #(.W(DATA_W)) u_buf_a (
    .clk     (clk),
    .reset   (reset),
    .d_i     (in_a),
    .valid_i (in_valid_a),
    .ready_o (in_ready_a),
    .take_i  (fire),
    .full_o  (a_full),
    .q_o     (a_q)
  );

  mac_opnd_buf #(.W(DATA_W)) u_buf_b (
    .clk     (clk),
    .reset   (reset),
    .d_i     (in_b),
    .valid_i (in_valid_b),
    .ready_o (in_ready_b),
    .take_i  (fire),
    .full_o  (b_full),
    .q_o     (b_q)
  );

  assign fire = a_full && b_full;
  assign last = (cnt_q == CNT_W'(VEC_LEN - 1));

  // First element samples the live mode; the rest reuse the latched one.
  assign eff_sgn = (cnt_q == '0) ? in_signed : mode_q;

  // Double-width product, then extended to the accumulator width.
  always_comb begin
    ps = PW'(signed'(a_q)) * PW'(signed'(b_q));
    pu = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    if (eff_sgn == MODE_SIGNED) begin
      pext = ACC_W'(ps);
    end else begin
      pext = ACC_W'(pu);
    end
  end

`ifdef MAC_SATURATE_EN
  logic [ACC_W:0] sum;

  // One guard bit detects overflow; clamp to the mode's range.
  always_comb begin
    sum   = '0;
    acc_n = '0;
    if (eff_sgn == MODE_SIGNED) begin
      sum = {acc_q[ACC_W-1], acc_q} + {pext[ACC_W-1], pext};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_n = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_n = sum[ACC_W-1:0];
      end
    end else begin
      sum = {1'b0, acc_q} + {1'b0, pext};
      acc_n = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end
  end
`else
  // Plain modular add; signedness only matters for the extension.
  always_comb begin
    acc_n = acc_q + pext;
  end
`endif

  // Accumulate on each fire; the final element publishes and rearms.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    mac_d  = mac_q;
    ov_d   = 1'b0;
    if (fire) begin
      if (cnt_q == '0) begin
        mode_d = in_signed;
      end
      if (last) begin
        mac_d = acc_n;
        ov_d  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_n;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accumulator, counter, mode and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_UNSIGNED;
      mac_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      mac_q  <= mac_d;
      ov_q   <= ov_d;
    end
  end

  assign mac_out   = mac_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_mac_vec.sv
// Scoreboard bench for mac_vec: an 11-bit and a 10-bit accumulator
// instance share one stimulus stream.
module tb_mac_vec;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic        in_valid_a = 1'b0;
  logic        in_valid_b = 1'b0;
  logic        in_signed = 1'b0;
  logic        rdy_a1, rdy_b1, ov1;
  logic        rdy_a2, rdy_b2, ov2;
  logic [10:0] mo1;
  logic [9:0]  mo2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int last_ov = 0;
  int last_acc = 0;
  int ov0;
  bit saw_ra_low = 1'b0;
  int q1[$];
  int q2[$];
  logic [31:0] rav, rbv;

  mac_vec #(.DATA_W(4), .VEC_LEN(8), .ACC_W(11)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(rdy_a1),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(rdy_b1),
    .in_signed(in_signed), .mac_out(mo1), .out_valid(ov1)
  );

  mac_vec #(.DATA_W(4), .VEC_LEN(8), .ACC_W(10)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(rdy_a2),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(rdy_b2),
    .in_signed(in_signed), .mac_out(mo2), .out_valid(ov2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [31:0] av, input logic [31:0] bv,
                               input bit sgn, input int accw);
    int acc;
    int p;
    int s;
    int mask;
    int hi;
    logic [3:0] a;
    logic [3:0] b;
    acc = 0;
    mask = (1 << accw) - 1;
    hi = 1 << (accw - 1);
    for (int i = 0; i < 8; i++) begin
      a = av[4*i +: 4];
      b = bv[4*i +: 4];
      if (sgn) p = int'($signed(a)) * int'($signed(b));
      else     p = int'(a) * int'(b);
`ifdef MAC_SATURATE_EN
      if (sgn) begin
        s = (acc >= hi) ? acc - (1 << accw) : acc;
        s = s + p;
        if (s > hi - 1) s = hi - 1;
        if (s < -hi) s = -hi;
        acc = s & mask;
      end else begin
        s = acc + p;
        if (s > mask) s = mask;
        acc = s;
      end
`else
      s = 0;
      acc = (acc + p) & mask;
`endif
    end
    return acc;
  endfunction

  // Result monitor: every strobe must match the oldest pending result.
  always @(negedge clk) begin
    if (ov1) begin
      ov_cnt++;
      last_ov = cyc;
      chk("ov1_pending", int'(q1.size() != 0), 1);
      if (q1.size() != 0) chk("mac_out1", int'(mo1), q1.pop_front());
    end
    if (ov2) begin
      chk("ov2_pending", int'(q2.size() != 0), 1);
      if (q2.size() != 0) chk("mac_out2", int'(mo2), q2.pop_front());
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input bit sgn, input int bgap, input bit flip,
                      input int n);
    int ia;
    int ib;
    int k;
    bit ta;
    bit tb;
    ia = 0;
    ib = 0;
    k = 0;
    while ((ia < n || ib < n) && k < 200) begin
      @(negedge clk);
      in_valid_a = (ia < n);
      in_a = av[4*(ia % 8) +: 4];
      in_valid_b = (ib < n) && (k % bgap == 0);
      in_b = bv[4*(ib % 8) +: 4];
      in_signed = (flip && ia > 3) ? !sgn : sgn;
      ta = in_valid_a && rdy_a1;
      tb = in_valid_b && rdy_b1;
      if (!rdy_a1) saw_ra_low = 1'b1;
      if (ta || tb) last_acc = cyc;
      @(posedge clk);
      if (ta) ia++;
      if (tb) ib++;
      k++;
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    chk("send_done", int'(ia >= n && ib >= n), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++)
      @(negedge clk);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);
    q1.delete();
    q2.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mo1"}, int'(mo1), 0);
    chk({tag, "_mo2"}, int'(mo2), 0);
    chk({tag, "_ov1"}, int'(ov1), 0);
    chk({tag, "_ov2"}, int'(ov2), 0);
    chk({tag, "_rdy_a"}, int'(rdy_a1 & rdy_a2), 1);
    chk({tag, "_rdy_b"}, int'(rdy_b1 & rdy_b2), 1);
  endtask

  initial begin
    #1;
    chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    q1.push_back(1800);
`ifdef MAC_SATURATE_EN
    q2.push_back(1023);
`else
    q2.push_back(776);
`endif
    ov0 = ov_cnt;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, 8);
    drain();
    chk("t1_strobes", ov_cnt - ov0, 1);
    chk("t1_latency", last_ov - last_acc, 2);
    repeat (3) @(negedge clk);
    chk("t1_hold", int'(mo1), 1800);

    q1.push_back(1600);
    q2.push_back(576);
    send(32'h8888_8888, 32'h7777_7777, 1'b1, 1, 1'b0, 8);
    drain();

    saw_ra_low = 1'b0;
    q1.push_back(36);
    q2.push_back(36);
    send(32'h8765_4321, 32'h1111_1111, 1'b0, 3, 1'b0, 8);
    drain();
    chk("t3_ready_a_low", int'(saw_ra_low), 1);

    q1.push_back(120);
    q2.push_back(120);
    send(32'hFFFF_FFFF, 32'h1111_1111, 1'b0, 1, 1'b1, 8);
    drain();

    send(32'h2222_2222, 32'h3333_3333, 1'b0, 1, 1'b0, 5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    reset = 1'b1;
    q1.push_back(48);
    q2.push_back(48);
    send(32'h2222_2222, 32'h3333_3333, 1'b0, 1, 1'b0, 8);
    drain();

    rav = $urandom;
    rbv = $urandom;
    q1.push_back(model(rav, rbv, 1'b1, 11));
    q2.push_back(model(rav, rbv, 1'b1, 10));
    send(rav, rbv, 1'b1, 2, 1'b0, 8);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
